// File: rtl/snake_pkg.sv
// Shared definitions for the snake playfield: cell codes, tile geometry and default palette.
// Also imported by the game-logic block so that both sides agree on codes and colours.
package snake_pkg;

    localparam int TILE_SHIFT = 4;

    localparam logic [1:0] CELL_EMPTY = 2'd0;
    localparam logic [1:0] CELL_BODY  = 2'd1;
    localparam logic [1:0] CELL_HEAD  = 2'd2;
    localparam logic [1:0] CELL_FOOD  = 2'd3;

    localparam logic [7:0] COLOR_BG   = 8'h00;
    localparam logic [7:0] COLOR_BODY = 8'h1C;
    localparam logic [7:0] COLOR_HEAD = 8'h1F;
    localparam logic [7:0] COLOR_FOOD = 8'hE0;
    localparam logic [7:0] COLOR_GRID = 8'h49;

    localparam logic [8:0] LAST_CELL = 9'd509;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_e;

    // Row-major cell index ty*30+tx; wraps mod 512 for off-map tiles, whose reads are never displayed.
    function automatic logic [8:0] tile_index(input logic [4:0] tx, input logic [4:0] ty);
        logic [8:0] t;
        t = {4'd0, ty};
        return (t << 5) - (t << 1) + {4'd0, tx};
    endfunction

endpackage

// File: rtl/snake_tile_ram.sv
// 512x2 simple dual-port tile map: one write port, one registered read port.
// Read-first: a same-cycle read of the written cell returns the previous code.
module snake_tile_ram (
    input  logic       clk,
    input  logic       we_i,
    input  logic [8:0] waddr_i,
    input  logic [1:0] wdata_i,
    input  logic [8:0] raddr_i,
    output logic [1:0] rdata_o
);

    logic [1:0] mem_q [512];
    logic [1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/snake_tile_render.sv
// Snake playfield pixel generator: three-stage scan-to-RGB332 pipeline over a 30x17 tile map,
// with a game-logic write port and a one-cell-per-clock map clear sweep.
module snake_tile_render
    import snake_pkg::*;
#(
    parameter logic [10:0] H_LINE  = 11'd480,
    parameter logic [10:0] V_LINE  = 11'd272,
    parameter logic [4:0]  TILES_X = 5'd30,
    parameter logic [4:0]  TILES_Y = 5'd17,
    parameter logic [7:0]  C_BG    = COLOR_BG,
    parameter logic [7:0]  C_BODY  = COLOR_BODY,
    parameter logic [7:0]  C_HEAD  = COLOR_HEAD,
    parameter logic [7:0]  C_FOOD  = COLOR_FOOD,
    parameter logic [7:0]  C_GRID  = COLOR_GRID,
    parameter bit          GRID_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rest_n,
    input  logic [10:0] i_x,
    input  logic [10:0] i_y,
    input  logic        i_de,
    output logic [7:0]  o_pixel,
    output logic        o_de,
    input  logic        wr_en,
    input  logic [4:0]  wr_x,
    input  logic [4:0]  wr_y,
    input  logic [1:0]  wr_code,
    output logic        wr_err,
    input  logic        clr,
    output logic        busy
);

    logic [8:0] idx0_q;
    logic       de0_q, area0_q, grid0_q;
    logic       de1_q, area1_q, grid1_q;
    logic [1:0] code1;
    logic [7:0] pix_d, pix_q;
    logic       de2_q;
    logic       wr_ok, wr_err_q;
    state_e     state_q, state_d;
    logic [8:0] cnt_q, cnt_d;
    logic       ram_we;
    logic [8:0] ram_waddr;
    logic [1:0] ram_wdata;

    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            idx0_q  <= '0;
            de0_q   <= 1'b0;
            area0_q <= 1'b0;
            grid0_q <= 1'b0;
            de1_q   <= 1'b0;
            area1_q <= 1'b0;
            grid1_q <= 1'b0;
            pix_q   <= 8'h00;
            de2_q   <= 1'b0;
        end else begin
            idx0_q  <= tile_index(i_x[TILE_SHIFT+4:TILE_SHIFT], i_y[TILE_SHIFT+4:TILE_SHIFT]);
            de0_q   <= i_de;
            area0_q <= (i_x < H_LINE) && (i_y < V_LINE);
            grid0_q <= (i_x[TILE_SHIFT-1:0] == '0) || (i_y[TILE_SHIFT-1:0] == '0);
            de1_q   <= de0_q;
            area1_q <= area0_q;
            grid1_q <= grid0_q;
            pix_q   <= pix_d;
            de2_q   <= de1_q;
        end
    end

    snake_tile_ram u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (idx0_q),
        .rdata_o (code1)
    );

    // Blanking beats off-screen, off-screen beats grid, grid beats cell contents.
    always_comb begin
        pix_d = 8'h00;
        if (!de1_q) begin
            pix_d = 8'h00;
        end else if (!area1_q) begin
            pix_d = C_BG;
        end else if (GRID_EN && grid1_q) begin
            pix_d = C_GRID;
        end else begin
            case (code1)
                CELL_BODY: pix_d = C_BODY;
                CELL_HEAD: pix_d = C_HEAD;
                CELL_FOOD: pix_d = C_FOOD;
                default:   pix_d = C_BG;
            endcase
        end
    end

    assign o_pixel = pix_q;
    assign o_de    = de2_q;

    assign wr_ok = wr_en && !busy && (wr_x < TILES_X) && (wr_y < TILES_Y);

    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_en && !wr_ok;
        end
    end

    assign wr_err = wr_err_q;

    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A clr request during a sweep is ignored; the sweep always runs to the last cell.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clr) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == LAST_CELL) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
        endcase
    end

    always_comb begin
        busy      = (state_q == ST_CLEAR);
        ram_we    = wr_ok;
        ram_waddr = tile_index(wr_x, wr_y);
        ram_wdata = wr_code;
        if (state_q == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = cnt_q;
            ram_wdata = CELL_EMPTY;
        end
    end

endmodule

// File: tb/tb_snake_tile_render.sv
// Self-checking bench for snake_tile_render: directed scenarios plus randomized writes and scans
// compared against a tile-map model evaluated with plain division/modulo arithmetic.
module tb_snake_tile_render;

    logic        clk = 1'b0;
    logic        rest_n;
    logic [10:0] i_x, i_y;
    logic        i_de;
    logic [7:0]  o_pixel;
    logic        o_de;
    logic        wr_en;
    logic [4:0]  wr_x, wr_y;
    logic [1:0]  wr_code;
    logic        wr_err;
    logic        clr;
    logic        busy;

    int checks = 0;
    int fails  = 0;
    logic [1:0] model_map [0:509];

    snake_tile_render dut (
        .clk     (clk),
        .rest_n  (rest_n),
        .i_x     (i_x),
        .i_y     (i_y),
        .i_de    (i_de),
        .o_pixel (o_pixel),
        .o_de    (o_de),
        .wr_en   (wr_en),
        .wr_x    (wr_x),
        .wr_y    (wr_y),
        .wr_code (wr_code),
        .wr_err  (wr_err),
        .clr     (clr),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] ref_pixel(input int x, input int y, input bit de);
        if (!de) return 8'h00;
        if (x >= 480 || y >= 272) return 8'h00;
        if (x % 16 == 0 || y % 16 == 0) return 8'h49;
        case (model_map[(y / 16) * 30 + x / 16])
            2'd1:    return 8'h1C;
            2'd2:    return 8'h1F;
            2'd3:    return 8'hE0;
            default: return 8'h00;
        endcase
    endfunction

    task automatic do_write(input int x, input int y, input logic [1:0] code,
                            input bit exp_busy, input string name);
        bit accept;
        accept = !exp_busy && x < 30 && y < 17;
        @(negedge clk);
        wr_en = 1'b1; wr_x = x[4:0]; wr_y = y[4:0]; wr_code = code;
        @(negedge clk);
        wr_en = 1'b0;
        checks++;
        if (wr_err !== !accept) begin
            fails++;
            $display("[TB] FAIL %s wr_err: got %b expected %b", name, wr_err, !accept);
        end
        if (accept) model_map[y * 30 + x] = code;
        @(negedge clk);
        checks++;
        if (wr_err !== 1'b0) begin
            fails++;
            $display("[TB] FAIL %s wr_err width: got %b expected 0", name, wr_err);
        end
    endtask

    task automatic scan_one(input int x, input int y, input string name);
        logic [7:0] exp_pix;
        exp_pix = ref_pixel(x, y, 1'b1);
        @(negedge clk);
        i_x = x[10:0]; i_y = y[10:0]; i_de = 1'b1;
        @(negedge clk);
        i_de = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (o_pixel !== exp_pix || o_de !== 1'b1) begin
            fails++;
            $display("[TB] FAIL %s (x=%0d y=%0d): got pixel %h de %b expected pixel %h de 1",
                     name, x, y, o_pixel, o_de, exp_pix);
        end
    endtask

    // mode 0: random coordinates and enables; mode 1: centre of every map cell in order.
    task automatic test_scan_stream(input int n, input int mode);
        logic [7:0] q_pix[$];
        bit         q_de[$];
        logic [7:0] ep;
        bit         ed;
        int x, y;
        bit de;
        for (int i = 0; i < n + 3; i++) begin
            @(negedge clk);
            if (q_pix.size() == 3) begin
                ep = q_pix.pop_front();
                ed = q_de.pop_front();
                checks++;
                if (o_pixel !== ep || o_de !== ed) begin
                    fails++;
                    $display("[TB] FAIL stream%0d item %0d: got pixel %h de %b expected pixel %h de %b",
                             mode, i - 3, o_pixel, o_de, ep, ed);
                end
            end
            if (i < n) begin
                if (mode == 0) begin
                    x  = $urandom_range(0, 520);
                    y  = $urandom_range(0, 290);
                    de = ($urandom_range(0, 7) != 0);
                end else begin
                    x  = (i % 30) * 16 + 8;
                    y  = (i / 30) * 16 + 8;
                    de = 1'b1;
                end
            end else begin
                x = 0; y = 0; de = 1'b0;
            end
            i_x = x[10:0]; i_y = y[10:0]; i_de = de;
            q_pix.push_back(ref_pixel(x, y, de));
            q_de.push_back(de);
        end
        i_de = 1'b0;
    endtask

    task automatic test_reset();
        int  cnt;
        bit  dirty;
        rest_n = 1'b1;
        #1 rest_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 4;
        if (o_pixel !== 8'h00) begin fails++; $display("[TB] FAIL reset o_pixel: got %h expected 00", o_pixel); end
        if (o_de !== 1'b0)     begin fails++; $display("[TB] FAIL reset o_de: got %b expected 0", o_de); end
        if (wr_err !== 1'b0)   begin fails++; $display("[TB] FAIL reset wr_err: got %b expected 0", wr_err); end
        if (busy !== 1'b1)     begin fails++; $display("[TB] FAIL reset busy: got %b expected 1", busy); end
        rest_n = 1'b1;
        cnt = 0;
        dirty = 1'b0;
        while (busy === 1'b1 && cnt < 2000) begin
            cnt++;
            if (o_pixel !== 8'h00 || o_de !== 1'b0) dirty = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (cnt != 510) begin
            fails++;
            $display("[TB] FAIL initial clear busy cycles: got %0d expected 510", cnt);
        end
        checks++;
        if (dirty) begin
            fails++;
            $display("[TB] FAIL outputs during clear: got nonzero pixel/de expected 00/0");
        end
        for (int i = 0; i < 510; i++) model_map[i] = 2'd0;
    endtask

    task automatic test_head_write();
        do_write(3, 2, 2'd2, 1'b0, "head write");
        scan_one(53, 37, "head pixel");
        scan_one(48, 37, "grid column");
    endtask

    task automatic test_food_corner();
        do_write(29, 16, 2'd3, 1'b0, "food write");
        scan_one(470, 270, "food corner");
        scan_one(480, 100, "right of area");
    endtask

    task automatic test_bad_writes();
        do_write(30, 2, 2'd1, 1'b0, "x out of range");
        do_write(3, 17, 2'd1, 1'b0, "y out of range");
        scan_one(53, 37, "head kept");
        scan_one(8, 56, "alias cell 90");
        scan_one(24, 8, "alias cell 1");
    endtask

    task automatic test_read_first();
        logic [7:0] exp_old;
        do_write(5, 5, 2'd3, 1'b0, "prime cell 155");
        exp_old = ref_pixel(88, 88, 1'b1);
        @(negedge clk);
        i_x = 11'd88; i_y = 11'd88; i_de = 1'b1;
        @(negedge clk);
        wr_en = 1'b1; wr_x = 5'd5; wr_y = 5'd5; wr_code = 2'd1;
        @(negedge clk);
        wr_en = 1'b0; i_de = 1'b0;
        model_map[155] = 2'd1;
        @(negedge clk);
        checks++;
        if (o_pixel !== exp_old || o_de !== 1'b1) begin
            fails++;
            $display("[TB] FAIL collision read: got pixel %h de %b expected pixel %h de 1", o_pixel, o_de, exp_old);
        end
        @(negedge clk);
        checks++;
        if (o_pixel !== 8'h1C || o_de !== 1'b1) begin
            fails++;
            $display("[TB] FAIL post-write read: got pixel %h de %b expected pixel 1c de 1", o_pixel, o_de);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_write($urandom_range(0, 31), $urandom_range(0, 31), 2'($urandom_range(0, 3)), 1'b0, "random write");
        end
        test_scan_stream(400, 0);
    endtask

    task automatic test_clear_abort();
        int cnt;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL clr start busy: got %b expected 1", busy);
        end
        repeat (8) @(negedge clk);
        do_write(4, 4, 2'd2, 1'b1, "write during clear");
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        i_x = 11'd24; i_y = 11'd24; i_de = 1'b1;
        repeat (85) @(negedge clk);
        rest_n = 1'b0;
        #1;
        checks += 4;
        if (o_pixel !== 8'h00) begin fails++; $display("[TB] FAIL abort o_pixel: got %h expected 00", o_pixel); end
        if (o_de !== 1'b0)     begin fails++; $display("[TB] FAIL abort o_de: got %b expected 0", o_de); end
        if (wr_err !== 1'b0)   begin fails++; $display("[TB] FAIL abort wr_err: got %b expected 0", wr_err); end
        if (busy !== 1'b1)     begin fails++; $display("[TB] FAIL abort busy: got %b expected 1", busy); end
        i_de = 1'b0;
        repeat (2) @(negedge clk);
        rest_n = 1'b1;
        cnt = 0;
        while (busy === 1'b1 && cnt < 2000) begin
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt != 510) begin
            fails++;
            $display("[TB] FAIL restarted clear busy cycles: got %0d expected 510", cnt);
        end
        for (int i = 0; i < 510; i++) model_map[i] = 2'd0;
        test_scan_stream(510, 1);
    endtask

    initial begin
        rest_n = 1'b1;
        i_x = '0; i_y = '0; i_de = 1'b0;
        wr_en = 1'b0; wr_x = '0; wr_y = '0; wr_code = '0;
        clr = 1'b0;
        test_reset();
        test_head_write();
        test_food_corner();
        test_bad_writes();
        test_read_first();
        test_random();
        test_clear_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
